ahb_interconnect: RTL and testbench

AHB-Lite address decoder and response multiplexer for the single-master Cortex-M0 system. It sits between the processor's AHB-Lite master port and up to four slaves, such as the word-organised RAM, ROM and peripherals. It drives each slave's HSEL during the address phase and steers the selected slave's HRDATA and HREADYOUT back to the master during the data phase. Accesses outside the map go to an internal default slave that returns a two-cycle ERROR response.

---
 rtl/ahb_pkg.sv | 37 +++
 rtl/ahb_default_slave.sv | 49 ++++
 rtl/ahb_interconnect.sv | 104 ++++++++++
 tb/tb_ahb_interconnect.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared constants and types for the AHB-Lite interconnect slice.
package ahb_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Default HADDR[31:16] match values per slot
  localparam logic [15:0] S0_BASE_DEFAULT = 16'h0000; // ROM
  localparam logic [15:0] S1_BASE_DEFAULT = 16'h2000; // RAM
  localparam logic [15:0] S2_BASE_DEFAULT = 16'h4000; // peripheral A
  localparam logic [15:0] S3_BASE_DEFAULT = 16'h5000; // peripheral B

  // Data-phase owner; slot values double as the response-mux index
  typedef enum logic [2:0] {
    DSEL_SLOT0   = 3'd0,
    DSEL_SLOT1   = 3'd1,
    DSEL_SLOT2   = 3'd2,
    DSEL_SLOT3   = 3'd3,
    DSEL_DEFAULT = 3'd4
  } dsel_e;

  // Default-slave response states
  typedef enum logic [1:0] {
    DS_OKAY = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // True for transfers that carry data (NONSEQ or SEQ)
  function automatic logic htrans_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped active transfers with a two-cycle ERROR,
// and unmapped IDLE/BUSY with a zero-wait OKAY.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HREADY,
  input  logic [1:0] HTRANS,
  input  logic       HSEL,
  output logic       HREADYOUT,
  output logic       HRESP
);

  ds_state_e state_q, state_d;
  logic      err_req;

  // An unmapped NONSEQ/SEQ accepted this cycle starts an error response
  assign err_req = HREADY & HSEL & htrans_active(HTRANS);

  // State register, asynchronously cleared to OKAY
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= DS_OKAY;
    else          state_q <= state_d;
  end

  // Next state and response; ERR2 always follows ERR1 whatever the master does
  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      DS_OKAY: begin
        if (err_req) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = DS_ERR2;
      end
      DS_ERR2: begin
        HRESP   = 1'b1;
        state_d = err_req ? DS_ERR1 : DS_OKAY;
      end
      default: state_d = DS_OKAY;
    endcase
  end

endmodule

// File: rtl/ahb_interconnect.sv
// AHB-Lite decoder and response mux for one master and up to four slaves,
// with an internal default slave for unmapped addresses.
module ahb_interconnect
  import ahb_pkg::*;
#(
  parameter logic [15:0] S0_BASE = S0_BASE_DEFAULT,
  parameter logic [15:0] S1_BASE = S1_BASE_DEFAULT,
  parameter logic [15:0] S2_BASE = S2_BASE_DEFAULT,
  parameter logic [15:0] S3_BASE = S3_BASE_DEFAULT
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  output logic [3:0]  HSEL_S,
  input  logic [31:0] HRDATA_S0,
  input  logic [31:0] HRDATA_S1,
  input  logic [31:0] HRDATA_S2,
  input  logic [31:0] HRDATA_S3,
  input  logic [3:0]  HREADYOUT_S,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  logic [15:0] base_arr [4];
  logic [31:0] rdata_s  [4];
  dsel_e       addr_dsel;
  dsel_e       dsel_q, dsel_d;
  logic        def_sel;
  logic        def_readyout;
  logic        def_resp;
  logic        unused_addr_lo;

  assign base_arr[0] = S0_BASE;
  assign base_arr[1] = S1_BASE;
  assign base_arr[2] = S2_BASE;
  assign base_arr[3] = S3_BASE;

  assign rdata_s[0] = HRDATA_S0;
  assign rdata_s[1] = HRDATA_S1;
  assign rdata_s[2] = HRDATA_S2;
  assign rdata_s[3] = HRDATA_S3;

  // Only the upper half-word takes part in decoding
  assign unused_addr_lo = ^HADDR[15:0];

  // Address-phase decode; not qualified by HTRANS or reset
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_decode
      assign HSEL_S[gi] = (HADDR[31:16] == base_arr[gi]);
    end
  endgenerate

  assign def_sel = ~|HSEL_S;

  // One-hot select to data-phase owner; anything else goes to the default slave
  always_comb begin
    addr_dsel = DSEL_DEFAULT;
    case (HSEL_S)
      4'b0001: addr_dsel = DSEL_SLOT0;
      4'b0010: addr_dsel = DSEL_SLOT1;
      4'b0100: addr_dsel = DSEL_SLOT2;
      4'b1000: addr_dsel = DSEL_SLOT3;
      default: addr_dsel = DSEL_DEFAULT;
    endcase
  end

  // The data-phase owner advances only when the current data phase completes
  always_comb begin
    dsel_d = dsel_q;
    if (HREADY) dsel_d = addr_dsel;
  end

  // Data-phase select register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) dsel_q <= DSEL_DEFAULT;
    else          dsel_q <= dsel_d;
  end

  ahb_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HREADY    (HREADY),
    .HTRANS    (HTRANS),
    .HSEL      (def_sel),
    .HREADYOUT (def_readyout),
    .HRESP     (def_resp)
  );

  // Steer the data-phase owner's response back to the master
  always_comb begin
    HRDATA = 32'h0;
    HREADY = def_readyout;
    HRESP  = def_resp;
    if (dsel_q != DSEL_DEFAULT) begin
      HRDATA = rdata_s[dsel_q[1:0]];
      HREADY = HREADYOUT_S[dsel_q[1:0]];
      HRESP  = 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_interconnect.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// cycle by cycle against a transfer-level reference model.
module tb_ahb_interconnect;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [3:0]  HSEL_S;
  logic [31:0] HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3;
  logic [3:0]  HREADYOUT_S;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  ahb_interconnect dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSEL_S      (HSEL_S),
    .HRDATA_S0   (HRDATA_S0),
    .HRDATA_S1   (HRDATA_S1),
    .HRDATA_S2   (HRDATA_S2),
    .HRDATA_S3   (HRDATA_S3),
    .HREADYOUT_S (HREADYOUT_S),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad   = 0;

  // Memory map as the master sees it
  localparam logic [15:0] MAP_BASE [4] = '{16'h0000, 16'h2000, 16'h4000, 16'h5000};

  // Reference model: who owns the data phase (4 = nobody mapped) and how
  // many error cycles of the current unmapped transfer have elapsed
  int m_owner;
  int m_err_cycle;   // 0 = no error, 1 = first error cycle, 2 = second

  // Samples taken in the last bus cycle, for directed checks
  logic [31:0] s_data;
  logic        s_ready, s_resp;
  logic [3:0]  s_hsel;
  logic        e_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int map_lookup(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (a[31:16] == MAP_BASE[i]) return i;
    return 4;
  endfunction

  function automatic logic [31:0] slave_data(input int idx);
    case (idx)
      0: return HRDATA_S0;
      1: return HRDATA_S1;
      2: return HRDATA_S2;
      default: return HRDATA_S3;
    endcase
  endfunction

  task automatic model_reset();
    m_owner     = 4;
    m_err_cycle = 0;
  endtask

  // One bus cycle: drive at negedge, check just after, advance model at posedge
  task automatic bus_cycle(input logic [31:0] a, input logic [1:0] t, input logic [3:0] ro,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
    int          dest;
    logic [3:0]  e_hsel;
    logic [31:0] e_data;
    logic        e_resp;
    @(negedge HCLK);
    HADDR = a; HTRANS = t; HREADYOUT_S = ro;
    HRDATA_S0 = d0; HRDATA_S1 = d1; HRDATA_S2 = d2; HRDATA_S3 = d3;
    #1;
    dest   = map_lookup(a);
    e_hsel = (dest < 4) ? 4'(1 << dest) : 4'b0000;
    if (m_owner < 4) begin
      e_data  = slave_data(m_owner);
      e_ready = ro[m_owner];
      e_resp  = 1'b0;
    end else begin
      e_data  = 32'h0;
      e_ready = (m_err_cycle != 1);
      e_resp  = (m_err_cycle != 0);
    end
    s_data = HRDATA; s_ready = HREADY; s_resp = HRESP; s_hsel = HSEL_S;
    chk("hsel",   {28'h0, HSEL_S}, {28'h0, e_hsel});
    chk("hrdata", HRDATA, e_data);
    chk("hready", {31'h0, HREADY}, {31'h0, e_ready});
    chk("hresp",  {31'h0, HRESP},  {31'h0, e_resp});
    @(posedge HCLK);
    if (m_err_cycle == 1) begin
      m_err_cycle = 2;
    end else if (e_ready) begin
      m_owner     = dest;
      m_err_cycle = (dest == 4 && t[1]) ? 1 : 0;
    end
  endtask

  task automatic idle_cycle(input logic [31:0] a);
    bus_cycle(a, 2'b00, 4'hF, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] a;
    HRESETn = 1'b0;
    HADDR = 32'h2000_0010; HTRANS = 2'b00; HREADYOUT_S = 4'hF;
    HRDATA_S0 = 32'h1111_1111; HRDATA_S1 = 32'h2222_2222;
    HRDATA_S2 = 32'h3333_3333; HRDATA_S3 = 32'h4444_4444;
    model_reset();

    // Reset state with an idle bus; decode works during reset
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_hsel",   {28'h0, HSEL_S}, 32'h2);
    chk("rst_hready", {31'h0, HREADY}, 32'h1);
    chk("rst_hresp",  {31'h0, HRESP},  32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    #3 HRESETn = 1'b1;

    // RAM read returning CAFE_F00D
    bus_cycle(32'h2000_0004, 2'b10, 4'hF, 32'h0, 32'h0, 32'h0, 32'h0);
    bus_cycle(32'h0000_0000, 2'b00, 4'hF, 32'h0, 32'hCAFE_F00D, 32'h0, 32'h0);
    chk("ram_rd_data", s_data, 32'hCAFE_F00D);
    chk("ram_rd_resp", {31'h0, s_resp}, 32'h0);

    // Slot 2 stretches for three cycles while slot 0 waits in the address phase
    bus_cycle(32'h4000_0008, 2'b10, 4'hF, 32'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      bus_cycle(32'h0000_0000, 2'b10, 4'b1011, 32'hDEAD_0000, 32'h0, w, 32'h0);
      chk("wait_ready", {31'h0, s_ready}, 32'h0);
      chk("wait_data",  s_data, w);
    end
    bus_cycle(32'h0000_0000, 2'b10, 4'hF, 32'hDEAD_0000, 32'h0, 32'h5A5A_0002, 32'h0);
    chk("wait_done", s_data, 32'h5A5A_0002);
    bus_cycle(32'h2000_0000, 2'b00, 4'hF, 32'h1234_5678, 32'h0, 32'h0, 32'h0);
    chk("slot0_after_wait", s_data, 32'h1234_5678);

    // Unmapped NONSEQ: ERR1, ERR2, then OKAY
    bus_cycle(32'h9000_0000, 2'b10, 4'hF, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("unmapped_hsel", {28'h0, s_hsel}, 32'h0);
    idle_cycle(32'h0000_0000);
    chk("err1_ready", {31'h0, s_ready}, 32'h0);
    chk("err1_resp",  {31'h0, s_resp},  32'h1);
    idle_cycle(32'h0000_0000);
    chk("err2_ready", {31'h0, s_ready}, 32'h1);
    chk("err2_resp",  {31'h0, s_resp},  32'h1);
    idle_cycle(32'h0000_0000);
    chk("err_done_resp", {31'h0, s_resp}, 32'h0);

    // Unmapped IDLE: zero-wait OKAY
    bus_cycle(32'h9000_0000, 2'b00, 4'hF, 32'h0, 32'h0, 32'h0, 32'h0);
    idle_cycle(32'h0000_0000);
    chk("idle_unmapped_ready", {31'h0, s_ready}, 32'h1);
    chk("idle_unmapped_resp",  {31'h0, s_resp},  32'h0);

    // Reset pulsed in ERR1 clears the response at once
    bus_cycle(32'h9000_0000, 2'b10, 4'hF, 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("pre_rst_err1_ready", {31'h0, HREADY}, 32'h0);
    HTRANS = 2'b00;
    #1 HRESETn = 1'b0;
    #1;
    chk("async_rst_ready",  {31'h0, HREADY}, 32'h1);
    chk("async_rst_resp",   {31'h0, HRESP},  32'h0);
    chk("async_rst_hrdata", HRDATA, 32'h0);
    model_reset();
    #1 HRESETn = 1'b1;
    bus_cycle(32'h2000_0000, 2'b10, 4'hF, 32'h0, 32'h0, 32'h0, 32'h0);
    bus_cycle(32'h0000_0000, 2'b00, 4'hF, 32'h0, 32'hBEEF_0001, 32'h0, 32'h0);
    chk("post_rst_data", s_data, 32'hBEEF_0001);
    chk("post_rst_resp", {31'h0, s_resp}, 32'h0);

    // Random traffic across all slots and unmapped space
    for (int n = 0; n < 3000; n++) begin
      int       kind;
      logic [3:0] ro;
      kind = $urandom_range(0, 5);
      if (kind < 4) a = {MAP_BASE[kind], 16'($urandom)};
      else          a = $urandom;
      for (int b = 0; b < 4; b++) ro[b] = ($urandom_range(0, 3) != 0);
      bus_cycle(a, 2'($urandom), ro, $urandom, $urandom, $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
